// File: rtl/alu_mult_arbiter.sv
// Round-robin arbiter and sequencer sharing one registered ALU among NREQ
// requesters: accept one operation, issue it for one cycle, wait the ALU
// latency, then hold the captured result on a valid/ready response channel.
module alu_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [3*NREQ-1:0]    req_a,
  input  logic [3*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 alu_en,
  output logic                 alu_rst_n,
  output logic [1:0]           alu_op,
  output logic [2:0]           alu_a,
  output logic [2:0]           alu_b,
  input  logic [5:0]           alu_dout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [5:0]           rsp_data,
  output logic [7:0]           ops_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // last_grant resets to the highest index so requester 0 wins first
  localparam logic [1:0] LAST_RST = 2'(NREQ - 1);
  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);
  localparam logic [2:0] NREQ_W   = 3'(NREQ);

  state_e      state_q, state_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  id_q, id_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  a_q, a_d;
  logic [2:0]  b_q, b_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  rsp_id_q, rsp_id_d;
  logic [5:0]  rsp_data_q, rsp_data_d;
  logic [7:0]  ops_q, ops_d;

  logic        win_vld_s;
  logic [1:0]  win_idx_s;
  logic [2:0]  cand_s;
  logic [3:0]  valid_pad_s;
  logic [7:0]  op_pad_s;
  logic [11:0] a_pad_s;
  logic [11:0] b_pad_s;
  logic [1:0]  win_op_s;
  logic [2:0]  win_a_s;
  logic [2:0]  win_b_s;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    win_vld_s   = 1'b0;
    win_idx_s   = 2'd0;
    cand_s      = 3'd0;
    valid_pad_s = 4'(req_valid);
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = {1'b0, last_grant_q} + 3'(k);
      if (cand_s >= NREQ_W) begin
        cand_s = cand_s - NREQ_W;
      end else begin
        cand_s = cand_s;
      end
      if (!win_vld_s && valid_pad_s[cand_s[1:0]]) begin
        win_vld_s = 1'b1;
        win_idx_s = cand_s[1:0];
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // Pick out the winning requester's op code and operands
  always_comb begin
    op_pad_s = 8'(req_op);
    a_pad_s  = 12'(req_a);
    b_pad_s  = 12'(req_b);
    case (win_idx_s)
      2'd0: begin win_op_s = op_pad_s[1:0]; win_a_s = a_pad_s[2:0];  win_b_s = b_pad_s[2:0];  end
      2'd1: begin win_op_s = op_pad_s[3:2]; win_a_s = a_pad_s[5:3];  win_b_s = b_pad_s[5:3];  end
      2'd2: begin win_op_s = op_pad_s[5:4]; win_a_s = a_pad_s[8:6];  win_b_s = b_pad_s[8:6];  end
      2'd3: begin win_op_s = op_pad_s[7:6]; win_a_s = a_pad_s[11:9]; win_b_s = b_pad_s[11:9]; end
      default: begin win_op_s = 2'd0; win_a_s = 3'd0; win_b_s = 3'd0; end
    endcase
  end

  // State register and datapath flops; rst abandons any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_RST;
      id_q         <= 2'd0;
      op_q         <= 2'd0;
      a_q          <= 3'd0;
      b_q          <= 3'd0;
      cnt_q        <= 3'd0;
      rsp_id_q     <= 2'd0;
      rsp_data_q   <= 6'd0;
      ops_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      ops_q        <= ops_d;
    end
  end

  // Next-state and next-datapath logic for the IDLE/ISSUE/WAIT/RESP sequence
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    ops_d        = ops_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld_s) begin
          op_d    = win_op_s;
          a_d     = win_a_s;
          b_d     = win_b_s;
          id_d    = win_idx_s;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          rsp_data_d = alu_dout;
          rsp_id_d   = id_q;
          cnt_d      = 3'd0;
          state_d    = S_RESP;
        end else begin
          cnt_d      = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          last_grant_d = id_q;
          ops_d        = ops_q + 8'd1;
          state_d      = S_IDLE;
        end else begin
          state_d      = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode; during rst the ALU is enabled with its reset asserted
  always_comb begin
    req_ready = '0;
    alu_en    = 1'b0;
    alu_op    = 2'd0;
    alu_a     = 3'd0;
    alu_b     = 3'd0;
    rsp_valid = 1'b0;
    alu_rst_n = ~rst;
    if (rst) begin
      alu_en = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = win_vld_s & (win_idx_s == 2'(i));
          end
        end
        S_ISSUE: begin
          alu_en = 1'b1;
          alu_op = op_q;
          alu_a  = a_q;
          alu_b  = b_q;
        end
        S_RESP: begin
          rsp_valid = 1'b1;
        end
        default: begin
          rsp_valid = 1'b0;
        end
      endcase
    end
  end

  assign rsp_id   = rsp_id_q;
  assign rsp_data = rsp_data_q;
  assign ops_done = ops_q;

endmodule

// File: tb/tb_alu_mult_arbiter.sv
// Bench for alu_mult_arbiter: two instances (ALU_LAT=1 and ALU_LAT=3) share
// stimulus; each has a behavioural ALU and a transaction-level reference model.
module tb_alu_mult_arbiter;

  logic        clk;
  logic        rst;
  logic        rsp_ready;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [11:0] req_a;
  logic [11:0] req_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state per instance
  bit         m_busy  [2];
  int         m_acc   [2];
  int         m_last  [2];
  logic [7:0] m_ops   [2];
  int         m_id    [2];
  logic [5:0] m_data  [2];
  logic [1:0] m_op    [2];
  logic [2:0] m_a     [2];
  logic [2:0] m_b     [2];
  bit         m_clean [2];
  // observations of DUT behaviour
  int         obs_cnt [2];
  int         obs_id  [2][8];
  int         obs_dat [2][8];
  int         rv_first[2];
  bit         rv_seen [2];
  int         en_cnt  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] alu_fn(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
    case (op)
      2'b00:   return 6'(a) + 6'(b);
      2'b01:   return 6'(a) - 6'(b);
      2'b10:   return 6'(a ^ b);
      default: return 6'(a) * 6'(b);
    endcase
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int last);
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = (last + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual %0d required %0d (cycle %0d)", nm, inst, act, exp, cyc);
    end
  endtask

  task automatic check_inst(input int i, input logic [3:0] rr, input logic en, input logic rstn,
                            input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                            input logic rv, input logic [1:0] rid, input logic [5:0] rd,
                            input logic [7:0] od);
    int k, w, lat;
    logic [3:0] exp_rr;
    bit exp_en, exp_rv;
    lat = (i == 0) ? 1 : 3;
    k   = cyc - m_acc[i];
    w   = rr_pick(req_valid, m_last[i]);
    if (rst) begin
      chk("alu_en_in_reset", i, 32'(en), 32'd1);
      chk("alu_rst_n_in_reset", i, 32'(rstn), 32'd0);
      chk("req_ready_in_reset", i, 32'(rr), 32'd0);
      chk("rsp_valid_in_reset", i, 32'(rv), 32'd0);
      m_busy[i] = 1'b0; m_last[i] = 3; m_ops[i] = 8'd0; m_clean[i] = 1'b1;
      obs_cnt[i] = 0; en_cnt[i] = 0; rv_seen[i] = 1'b0;
    end else begin
      exp_rr = (!m_busy[i] && w >= 0) ? 4'(4'b0001 << w) : 4'b0000;
      exp_en = m_busy[i] && (k == 0);
      exp_rv = m_busy[i] && (k > lat);
      chk("alu_rst_n", i, 32'(rstn), 32'd1);
      chk("req_ready", i, 32'(rr), 32'(exp_rr));
      chk("alu_en", i, 32'(en), 32'(exp_en));
      chk("alu_op", i, 32'(op), exp_en ? 32'(m_op[i]) : 32'd0);
      chk("alu_a", i, 32'(a), exp_en ? 32'(m_a[i]) : 32'd0);
      chk("alu_b", i, 32'(b), exp_en ? 32'(m_b[i]) : 32'd0);
      chk("rsp_valid", i, 32'(rv), 32'(exp_rv));
      if (exp_rv) begin
        chk("rsp_data", i, 32'(rd), 32'(m_data[i]));
        chk("rsp_id", i, 32'(rid), 32'(m_id[i]));
      end
      if (m_clean[i]) begin
        chk("rsp_data_after_reset", i, 32'(rd), 32'd0);
        chk("rsp_id_after_reset", i, 32'(rid), 32'd0);
      end
      chk("ops_done", i, 32'(od), 32'(m_ops[i]));
      if (en === 1'b1) en_cnt[i]++;
      if (m_busy[i] && rv === 1'b1 && !rv_seen[i]) begin
        rv_seen[i]  = 1'b1;
        rv_first[i] = k + 1;
      end
      if (rv === 1'b1 && rsp_ready) begin
        if (obs_cnt[i] < 8) begin
          obs_id[i][obs_cnt[i]]  = int'(rid);
          obs_dat[i][obs_cnt[i]] = int'(rd);
        end
        obs_cnt[i]++;
      end
      // advance the model across the coming clock edge
      if (!m_busy[i]) begin
        if (w >= 0) begin
          m_busy[i]  = 1'b1;
          m_acc[i]   = cyc + 1;
          m_id[i]    = w;
          m_op[i]    = req_op[2*w +: 2];
          m_a[i]     = req_a[3*w +: 3];
          m_b[i]     = req_b[3*w +: 3];
          m_data[i]  = alu_fn(m_op[i], m_a[i], m_b[i]);
          m_clean[i] = 1'b0;
          rv_seen[i] = 1'b0;
        end
      end else if (k > lat && rsp_ready) begin
        m_busy[i] = 1'b0;
        m_last[i] = m_id[i];
        m_ops[i]  = m_ops[i] + 8'd1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_inst(0, gen_inst[0].req_ready, gen_inst[0].alu_en, gen_inst[0].alu_rst_n, gen_inst[0].alu_op,
               gen_inst[0].alu_a, gen_inst[0].alu_b, gen_inst[0].rsp_valid, gen_inst[0].rsp_id,
               gen_inst[0].rsp_data, gen_inst[0].ops_done);
    check_inst(1, gen_inst[1].req_ready, gen_inst[1].alu_en, gen_inst[1].alu_rst_n, gen_inst[1].alu_op,
               gen_inst[1].alu_a, gen_inst[1].alu_b, gen_inst[1].rsp_valid, gen_inst[1].rsp_id,
               gen_inst[1].rsp_data, gen_inst[1].ops_done);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
    req_op[2*i +: 2] = op;
    req_a[3*i +: 3]  = a;
    req_b[3*i +: 3]  = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_until(input int n, input int bound);
    int t = 0;
    while ((obs_cnt[0] < n || obs_cnt[1] < n) && t < bound) begin
      step();
      t++;
    end
    chk("response_timeout", 0, 32'(obs_cnt[0] >= n && obs_cnt[1] >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((m_busy[0] || m_busy[1]) && t < 100) begin
      step();
      t++;
    end
    chk("idle_timeout", 0, 32'(m_busy[0] || m_busy[1]), 32'd0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [3:0] req_ready;
    logic       alu_en;
    logic       alu_rst_n;
    logic [1:0] alu_op;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [5:0] alu_dout;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [5:0] rsp_data;
    logic [7:0] ops_done;
    logic [5:0] pipe [LAT];

    alu_mult_arbiter #(.NREQ(4), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .alu_en(alu_en), .alu_rst_n(alu_rst_n), .alu_op(alu_op), .alu_a(alu_a),
      .alu_b(alu_b), .alu_dout(alu_dout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .ops_done(ops_done)
    );

    // behavioural ALU: samples when enabled, result appears LAT edges later
    always @(posedge clk) begin
      if (alu_en && !alu_rst_n) begin
        for (int s = 0; s < LAT; s++) pipe[s] <= 6'd0;
      end else begin
        if (alu_en) pipe[0] <= alu_fn(alu_op, alu_a, alu_b);
        for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
      end
    end
    assign alu_dout = pipe[LAT-1];
  end

  int rr_id_exp [5] = '{0, 1, 2, 3, 0};
  int rr_dat_exp[5] = '{7, 14, 21, 28, 7};

  initial begin
    int base0, base1, t;
    rst = 1'b1; rsp_ready = 1'b1; req_valid = 4'd0; req_op = 8'd0; req_a = 12'd0; req_b = 12'd0;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_acc[i] = 0; m_last[i] = 3; m_ops[i] = 8'd0; m_clean[i] = 1'b1;
      obs_cnt[i] = 0; rv_first[i] = 0; rv_seen[i] = 1'b0; en_cnt[i] = 0;
    end

    // reset, then idle release
    do_reset();
    step();
    chk("alu_en_after_reset", 0, 32'(gen_inst[0].alu_en), 32'd0);
    chk("ops_done_after_reset", 0, 32'(gen_inst[0].ops_done), 32'd0);

    // single multiply on requester 0
    set_req(0, 2'b11, 3'd5, 3'd3);
    req_valid = 4'b0001;
    #1;
    chk("single_req_ready", 0, 32'(gen_inst[0].req_ready), 32'd1);
    step();
    req_valid = 4'b0000;
    run_until(1, 30);
    chk("single_data", 0, 32'(obs_dat[0][0]), 32'd15);
    chk("single_id", 0, 32'(obs_id[0][0]), 32'd0);
    chk("single_latency", 0, 32'(rv_first[0]), 32'd3);
    chk("single_en_pulses", 0, 32'(en_cnt[0]), 32'd1);
    chk("single_ops_done", 0, 32'(gen_inst[0].ops_done), 32'd1);
    chk("single_data", 1, 32'(obs_dat[1][0]), 32'd15);
    wait_idle();

    // round-robin with all four requesters held valid
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'b11, 3'(i + 1), 3'd7);
    req_valid = 4'b1111;
    run_until(5, 100);
    req_valid = 4'b0000;
    wait_idle();
    for (int j = 0; j < 5; j++) begin
      chk("rr_id", 0, 32'(obs_id[0][j]), 32'(rr_id_exp[j]));
      chk("rr_data", 0, 32'(obs_dat[0][j]), 32'(rr_dat_exp[j]));
      chk("rr_id", 1, 32'(obs_id[1][j]), 32'(rr_id_exp[j]));
      chk("rr_data", 1, 32'(obs_dat[1][j]), 32'(rr_dat_exp[j]));
    end

    // backpressure: 7*7 held while rsp_ready is low
    rsp_ready = 1'b0;
    set_req(1, 2'b11, 3'd7, 3'd7);
    req_valid = 4'b0010;
    step();
    set_req(3, 2'b11, 3'd2, 3'd2);
    req_valid = 4'b1000;
    t = 0;
    while (!(gen_inst[0].rsp_valid && gen_inst[1].rsp_valid) && t < 20) begin
      step();
      t++;
    end
    chk("bp_reach_resp", 0, 32'(gen_inst[0].rsp_valid && gen_inst[1].rsp_valid), 32'd1);
    repeat (5) step();
    base0 = obs_cnt[0];
    base1 = obs_cnt[1];
    chk("bp_data_held", 0, 32'(gen_inst[0].rsp_data), 32'd49);
    chk("bp_data_held", 1, 32'(gen_inst[1].rsp_data), 32'd49);
    chk("bp_req_ready", 0, 32'(gen_inst[0].req_ready), 32'd0);
    chk("bp_req_ready", 1, 32'(gen_inst[1].req_ready), 32'd0);
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    step();
    chk("bp_single_release", 0, 32'(obs_cnt[0] - base0), 32'd1);
    chk("bp_single_release", 1, 32'(obs_cnt[1] - base1), 32'd1);
    wait_idle();

    // reset while waiting on the ALU
    set_req(2, 2'b01, 3'd6, 3'd2);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 2'b11, 3'd2, 3'd3);
    set_req(3, 2'b11, 3'd4, 3'd5);
    req_valid = 4'b1001;
    #1;
    chk("post_reset_grant", 0, 32'(gen_inst[0].req_ready), 32'd1);
    chk("post_reset_grant", 1, 32'(gen_inst[1].req_ready), 32'd1);
    step();
    req_valid = 4'b0000;
    run_until(1, 30);
    chk("post_reset_id", 0, 32'(obs_id[0][0]), 32'd0);
    chk("post_reset_data", 0, 32'(obs_dat[0][0]), 32'd6);
    wait_idle();
    set_req(3, 2'b10, 3'd5, 3'd3);
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    run_until(2, 30);
    chk("xor_op_data", 0, 32'(obs_dat[0][1]), 32'd6);
    wait_idle();

    // latency parameter and ops_done wrap
    do_reset();
    set_req(0, 2'b11, 3'd6, 3'd5);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    run_until(1, 30);
    chk("lat3_data", 1, 32'(obs_dat[1][0]), 32'd30);
    chk("lat3_latency", 1, 32'(rv_first[1]), 32'd5);
    chk("lat1_latency", 0, 32'(rv_first[0]), 32'd3);
    wait_idle();
    for (int i = 0; i < 4; i++) set_req(i, 2'b11, 3'(i + 2), 3'd3);
    req_valid = 4'b1111;
    t = 0;
    while (obs_cnt[1] < 256 && t < 3000) begin
      step();
      t++;
    end
    chk("wrap_count_reached", 1, 32'(obs_cnt[1]), 32'd256);
    chk("ops_done_wrap", 1, 32'(gen_inst[1].ops_done), 32'd0);
    req_valid = 4'b0000;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mult_arbiter.md
# alu_mult_arbiter

Round-robin arbiter and sequencer that shares one ALU multiplier datapath among `NREQ` requesters. It accepts one operation at a time over a valid/ready handshake, drives the ALU's enable/op/operand/reset inputs for exactly one issue cycle, and waits the ALU's registered latency. It then returns the captured 6-bit result with the requester ID over a valid/ready response channel. It sits between the control units and the ALU and is the only block allowed to drive ALU inputs.

## Interface
- `NREQ`, 4: number of requesters, 2..4; `rsp_id` and `last_grant` stay 2 bits wide.
- `ALU_LAT`, 1: cycles from the issue clock edge until `alu_dout` is valid, 1..7.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in NREQ: per-requester operation valid.
- `req_op` in 2·NREQ: op code for requester i at `[2i+:2]`.
- `req_a` in 3·NREQ: operand A for requester i at `[3i+:3]`.
- `req_b` in 3·NREQ: operand B for requester i at `[3i+:3]`.
- `req_ready` out NREQ: one-hot accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `alu_en` out 1: ALU enable.
- `alu_rst_n` out 1: ALU active-low reset, equal to `~rst`.
- `alu_op` out 2: op code to the ALU.
- `alu_a` out 3: operand A to the ALU.
- `alu_b` out 3: operand B to the ALU.
- `alu_dout` in 6: ALU result bus.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out 2: index of the requester that owns the result.
- `rsp_data` out 6: captured result.
- `ops_done` out 8: count of completed responses; wraps 255→0.

## Operation
- Four-state FSM: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - Winner is the first `i` with `req_valid[i]=1`, searching from `last_grant+1` upward modulo NREQ.
  - `req_ready[winner]=1` combinationally in IDLE only; all other `req_ready` bits are 0.
  - On transfer: register op/A/B into `op_q/a_q/b_q`, register the winner into `id_q`, go to ISSUE.
  - If no request is valid, stay in IDLE.
- **ISSUE**
  - Exactly one cycle, with `alu_en=1`, `alu_op=op_q`, `alu_a=a_q`, `alu_b=b_q`.
  - Load the latency counter with `ALU_LAT`, go to WAIT.
- **WAIT**
  - `alu_en=0`; decrement the counter each cycle.
  - When the counter equals 1: capture `alu_dout` into `rsp_data`, `id_q` into `rsp_id`, go to RESP.
- **RESP**
  - `rsp_valid=1`; `rsp_data` and `rsp_id` are held stable while `rsp_ready=0`.
  - On `rsp_ready=1`:
    - update `last_grant<=id_q`;
    - increment `ops_done` (mod 256);
    - go to IDLE.
  - No new request is accepted before the response is consumed.
- Op codes are forwarded verbatim; the arbiter does not decode them. Op `2'b11` selects multiply, and the result is A×B, 0..49.
- Outside ISSUE and reset: `alu_en=0`; `alu_op/a/b` are driven 0.
- **Reset**
  - While `rst=1`: `alu_en=1` and `alu_rst_n=0`, so the ALU, which only honours reset while enabled, clears its result register in the same cycles.
  - State goes to IDLE; `last_grant=NREQ-1`, so requester 0 has first priority.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `ops_done=0`, `req_ready=0`.
- Reset in any state abandons the in-flight operation; no response is produced for it.

## Timing
- Accept at edge T0 (IDLE). `alu_en` is high during cycle T0+1 (ISSUE), and the ALU samples at edge T0+2.
- `rsp_valid` rises after edge T0+2+ALU_LAT−1+1. For ALU_LAT=1: `rsp_valid` is high in cycle T0+3.
- Minimum request-to-request spacing is 3+ALU_LAT cycles when `rsp_ready` is held high.
- `req_ready` depends only on state, `last_grant` and `req_valid`. It never depends on `rsp_ready`.
- A requester that deasserts `req_valid` before its transfer loses the slot; the arbiter re-evaluates every IDLE cycle.
- Simultaneous `rsp_ready=1` and a new `req_valid` in the RESP cycle: the new request is not accepted until the following cycle (IDLE).
- `rst` overrides every other input in the cycle it is sampled.

## Test plan
- **Reset:** `rst=1` for 2 cycles. Required: `alu_en=1`, `alu_rst_n=0`, `rsp_valid=0`, `ops_done=0`, `req_ready=0`. After release: `alu_en=0`.
- **Single multiply:** req0 op=11, A=5, B=3, `rsp_ready=1`. Required: `req_ready[0]` in cycle 0, `alu_en` high for exactly 1 cycle, `rsp_valid` in cycle 3, `rsp_data=15`, `rsp_id=0`, `ops_done=1`.
- **Round-robin:** all 4 requests held valid (A=i+1, B=7) continuously. Required: grant order 0,1,2,3,0; `rsp_data` 7,14,21,28,7.
- **Backpressure:** A=7, B=7, `rsp_ready=0` for 5 cycles. Required: `rsp_data=49` held stable, `req_ready=0` throughout, a single `ops_done` increment on release.
- **Reset mid-operation:** assert `rst` during WAIT. Required: no response, FSM in IDLE, next grant goes to req0.
- **Latency parameter:** ALU_LAT=3, A=6, B=5. Required: `rsp_valid` in cycle 5 after accept, `rsp_data=30`; `ops_done` wraps to 0 after 256 operations.
